// File: rtl/mem_uart_streamer_pkg.sv
// -----------------------------------------------------------------------------
// mem_uart_streamer_pkg
// Shared types and constants for the memory-to-UART block streamer:
//   - ctl_state_t : address/controller FSM states
//   - tx_state_t  : UART transmitter FSM states
//   - 8N1 frame constants (data bit count, start/stop/idle line levels)
//   - counter widths used by the transmitter
// -----------------------------------------------------------------------------
package mem_uart_streamer_pkg;

    typedef enum logic [2:0] {
        CTL_IDLE,
        CTL_FETCH,
        CTL_SEND,
        CTL_WAIT_TX,
        CTL_NEXT,
        CTL_DONE
    } ctl_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP,
        TX_CLEANUP
    } tx_state_t;

    localparam int   UART_DATA_BITS   = 8;
    localparam int   UART_BIT_IDX_W   = 3;
    localparam int   BAUD_CNT_W       = 16;
    localparam logic UART_START_LEVEL = 1'b0;
    localparam logic UART_STOP_LEVEL  = 1'b1;
    localparam logic UART_IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/mem_uart_streamer_if.sv
// -----------------------------------------------------------------------------
// mem_uart_streamer_if
// Bundles the streamer's memory-side and UART-side signals.
//   i_Start      active-low start request (driven by the environment)
//   i_Data       synchronous RAM read data for o_Addr
//   o_Addr       RAM read address
//   o_Tx_DV      one-cycle transmitter load strobe
//   o_Tx_Active  high while a frame is on the line
//   o_Tx_Serial  UART line, idles high
//   o_Tx_Done    one-cycle end-of-frame pulse
//   o_Busy       transfer in progress
//   o_Fin        transfer complete, held until next accepted start
// Modports: master = environment side, slave = streamer side.
// -----------------------------------------------------------------------------
interface mem_uart_streamer_if #(
    parameter int ADDR_W = 16
);
    logic              i_Start;
    logic [7:0]        i_Data;
    logic [ADDR_W-1:0] o_Addr;
    logic              o_Tx_DV;
    logic              o_Tx_Active;
    logic              o_Tx_Serial;
    logic              o_Tx_Done;
    logic              o_Busy;
    logic              o_Fin;

    modport master (
        output i_Start, i_Data,
        input  o_Addr, o_Tx_DV, o_Tx_Active, o_Tx_Serial, o_Tx_Done, o_Busy, o_Fin
    );

    modport slave (
        input  i_Start, i_Data,
        output o_Addr, o_Tx_DV, o_Tx_Active, o_Tx_Serial, o_Tx_Done, o_Busy, o_Fin
    );
endinterface

// File: rtl/mem_uart_streamer_uart_tx_core.sv
// -----------------------------------------------------------------------------
// uart_tx_core
// 8N1 UART transmitter, LSB first.
//   i_Clock      system clock
//   i_Reset      asynchronous active-high reset (line forced high)
//   i_Tx_DV      load strobe; only honoured while IDLE
//   i_Tx_Byte    byte latched on i_Tx_DV
//   o_Tx_Active  high from the cycle after the load until the end-of-frame pulse
//   o_Tx_Serial  serial line
//   o_Tx_Done    one-cycle pulse once the stop bit has completed
// The line level is registered on the state transition, so the start bit
// appears in the first cycle after the load rather than one cycle later.
// -----------------------------------------------------------------------------
module uart_tx_core
    import mem_uart_streamer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Active,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Done
);

    localparam logic [BAUD_CNT_W-1:0]     BAUD_LAST = BAUD_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [UART_BIT_IDX_W-1:0] BIT_LAST  = UART_BIT_IDX_W'(UART_DATA_BITS - 1);

    tx_state_t                 state;
    tx_state_t                 state_nxt;
    logic [BAUD_CNT_W-1:0]     baud_cnt;
    logic [UART_BIT_IDX_W-1:0] bit_idx;
    logic [7:0]                shreg;
    logic                      bit_end;
    logic                      load;

    assign bit_end = (baud_cnt == BAUD_LAST);
    assign load    = (state == TX_IDLE) && i_Tx_DV;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) state <= TX_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TX_IDLE:    if (i_Tx_DV) state_nxt = TX_START;
            TX_START:   if (bit_end) state_nxt = TX_DATA;
            TX_DATA:    if (bit_end && (bit_idx == BIT_LAST)) state_nxt = TX_STOP;
            TX_STOP:    if (bit_end) state_nxt = TX_CLEANUP;
            TX_CLEANUP: state_nxt = TX_IDLE;
            default:    state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            baud_cnt    <= '0;
            bit_idx     <= '0;
            o_Tx_Active <= 1'b0;
            o_Tx_Serial <= UART_IDLE_LEVEL;
            o_Tx_Done   <= 1'b0;
        end else begin
            o_Tx_Done <= 1'b0;
            case (state)
                TX_IDLE: begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (i_Tx_DV) begin
                        o_Tx_Active <= 1'b1;
                        o_Tx_Serial <= UART_START_LEVEL;
                    end
                end
                TX_START: begin
                    if (bit_end) begin
                        baud_cnt    <= '0;
                        o_Tx_Serial <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == BIT_LAST) begin
                            bit_idx     <= '0;
                            o_Tx_Serial <= UART_STOP_LEVEL;
                        end else begin
                            bit_idx     <= bit_idx + 1'b1;
                            o_Tx_Serial <= shreg[0];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (bit_end) begin
                        baud_cnt    <= '0;
                        o_Tx_Done   <= 1'b1;
                        o_Tx_Active <= 1'b0;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    baud_cnt <= '0;
                end
            endcase
        end
    end

    // Shift register pre-positions the next data bit at bit 0 each time a bit
    // period ends, so the line update above only ever looks at shreg[0].
    always_ff @(posedge i_Clock) begin
        if (load) begin
            shreg <= i_Tx_Byte;
        end else if (bit_end && ((state == TX_START) ||
                                 ((state == TX_DATA) && (bit_idx != BIT_LAST)))) begin
            shreg <= {1'b0, shreg[7:1]};
        end
    end

endmodule

// File: rtl/mem_uart_streamer.sv
// -----------------------------------------------------------------------------
// mem_uart_streamer
// Walks addresses 0..LAST_ADDR of a synchronous byte RAM and sends each byte
// as one 8N1 UART frame; raises o_Fin when the last frame has completed.
//   i_Clock  system clock
//   i_Reset  asynchronous active-high reset
//   bus      mem_uart_streamer_if.slave (start, RAM port, UART, status)
// Parameters: CLKS_PER_BIT (2..65535), ADDR_W, LAST_ADDR.
// -----------------------------------------------------------------------------
module mem_uart_streamer
    import mem_uart_streamer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int ADDR_W       = 16,
    parameter int LAST_ADDR    = 65535
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    mem_uart_streamer_if.slave    bus
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

    ctl_state_t        state;
    ctl_state_t        state_nxt;
    logic              start_q1;
    logic              start_q2;
    logic              start_fall;
    logic              tx_dv;
    logic              tx_done;
    logic              load_start;
    logic              finish;
    logic              advance;
    logic [ADDR_W-1:0] addr;
    logic              busy;
    logic              fin;

    // start_q1 samples the asynchronous request; start_q2 is its history, so a
    // level held low yields a single-cycle edge and can never retrigger.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            start_q1 <= 1'b1;
            start_q2 <= 1'b1;
        end else begin
            start_q1 <= bus.i_Start;
            start_q2 <= start_q1;
        end
    end

    assign start_fall = start_q2 & ~start_q1;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) state <= CTL_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        load_start = 1'b0;
        finish     = 1'b0;
        advance    = 1'b0;
        case (state)
            CTL_IDLE, CTL_DONE: begin
                if (start_fall) begin
                    load_start = 1'b1;
                    state_nxt  = CTL_FETCH;
                end
            end
            CTL_FETCH: state_nxt = CTL_SEND;
            CTL_SEND:  state_nxt = CTL_WAIT_TX;
            CTL_WAIT_TX: begin
                if (tx_done) begin
                    if (addr == LAST) begin
                        finish    = 1'b1;
                        state_nxt = CTL_DONE;
                    end else begin
                        state_nxt = CTL_NEXT;
                    end
                end
            end
            CTL_NEXT: begin
                advance   = 1'b1;
                state_nxt = CTL_FETCH;
            end
            default: state_nxt = CTL_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            addr <= '0;
            busy <= 1'b0;
            fin  <= 1'b0;
        end else begin
            if (load_start) begin
                addr <= '0;
                busy <= 1'b1;
                fin  <= 1'b0;
            end else if (finish) begin
                busy <= 1'b0;
                fin  <= 1'b1;
            end else if (advance) begin
                addr <= addr + 1'b1;
            end
        end
    end

    // The RAM answers one cycle after the address settles (during FETCH), so
    // i_Data is valid while SEND strobes the transmitter.
    assign tx_dv = (state == CTL_SEND);

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .i_Clock    (i_Clock),
        .i_Reset    (i_Reset),
        .i_Tx_DV    (tx_dv),
        .i_Tx_Byte  (bus.i_Data),
        .o_Tx_Active(bus.o_Tx_Active),
        .o_Tx_Serial(bus.o_Tx_Serial),
        .o_Tx_Done  (tx_done)
    );

    assign bus.o_Addr    = addr;
    assign bus.o_Tx_DV   = tx_dv;
    assign bus.o_Tx_Done = tx_done;
    assign bus.o_Busy    = busy;
    assign bus.o_Fin     = fin;

endmodule

// File: tb/tb_mem_uart_streamer.sv
// -----------------------------------------------------------------------------
// tb_mem_uart_streamer
// Scoreboard bench for mem_uart_streamer with CLKS_PER_BIT=4, LAST_ADDR=3.
// Stimulus pushes the expected (address, byte) of each frame; a monitor
// decodes every frame from the line and compares against the queue.
// -----------------------------------------------------------------------------
module tb_mem_uart_streamer;

    localparam int CPB    = 4;
    localparam int ADDR_W = 16;
    localparam int LASTA  = 3;

    typedef struct {
        int         addr;
        logic [7:0] data;
        bit         last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    mem_uart_streamer_if #(.ADDR_W(ADDR_W)) bus ();

    mem_uart_streamer #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (ADDR_W),
        .LAST_ADDR   (LASTA)
    ) dut (
        .i_Clock(clk),
        .i_Reset(rst),
        .bus    (bus)
    );

    always #50 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM model: mode 0 -> constant 0x3B, mode 1 -> addr ^ 0xA5
    bit mode = 1'b0;
    always @(posedge clk) bus.i_Data <= mode ? (bus.o_Addr[7:0] ^ 8'hA5) : 8'h3B;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    bit   mon_en = 1'b1;
    int   prev_dv = -1;
    int   frames = 0;
    int   fin_rises = 0;
    logic fin_prev = 1'b0;

    // Hand-computed frame contents
    logic [7:0] tbl_a5 [4] = '{8'hA5, 8'hA4, 8'hA7, 8'hA6};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.o_Fin === 1'b1 && fin_prev === 1'b0) fin_rises++;
        fin_prev = bus.o_Fin;
    end

    // Monitor: decodes one frame per DV strobe
    int         m_dv_cyc;
    int         m_addr;
    logic [9:0] m_lv;
    bit         m_glitch;
    bit         m_act_bad;
    exp_t       m_e;
    always begin
        @(negedge clk);
        if (mon_en && bus.o_Tx_DV === 1'b1) begin
            m_dv_cyc = cyc;
            m_addr   = int'(bus.o_Addr);
            if (prev_dv >= 0) chk("dv_spacing", 32'(m_dv_cyc - prev_dv), 32'(10 * CPB + 4));
            prev_dv   = m_dv_cyc;
            m_glitch  = 1'b0;
            m_act_bad = 1'b0;
            for (int b = 0; b < 10; b++) begin
                for (int k = 0; k < CPB; k++) begin
                    @(negedge clk);
                    if (k == 0) m_lv[b] = bus.o_Tx_Serial;
                    else if (bus.o_Tx_Serial !== m_lv[b]) m_glitch = 1'b1;
                    if (bus.o_Tx_Active !== 1'b1) m_act_bad = 1'b1;
                end
            end
            chk("start_bit", 32'(m_lv[0]), 32'd0);
            chk("stop_bit", 32'(m_lv[9]), 32'd1);
            chk("bit_width", 32'(m_glitch), 32'd0);
            chk("active_during_frame", 32'(m_act_bad), 32'd0);
            @(negedge clk);
            chk("tx_done_pulse", 32'(bus.o_Tx_Done), 32'd1);
            chk("active_fall", 32'(bus.o_Tx_Active), 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_frame", 32'(m_lv[8:1]), 32'hFFFF_FFFF);
            end else begin
                m_e = sb.pop_front();
                frames++;
                chk("frame_addr", 32'(m_addr), 32'(m_e.addr));
                chk("frame_byte", 32'(m_lv[8:1]), 32'(m_e.data));
                @(negedge clk);
                chk("tx_done_one_cycle", 32'(bus.o_Tx_Done), 32'd0);
                chk("fin_after_frame", 32'(bus.o_Fin), 32'(m_e.last));
                chk("busy_after_frame", 32'(bus.o_Busy), 32'(!m_e.last));
            end
        end
    end

    task automatic push_const();
        exp_t e;
        for (int a = 0; a <= LASTA; a++) begin
            e.addr = a; e.data = 8'h3B; e.last = (a == LASTA);
            sb.push_back(e);
        end
    endtask

    task automatic push_tbl();
        exp_t e;
        for (int a = 0; a <= LASTA; a++) begin
            e.addr = a; e.data = tbl_a5[a]; e.last = (a == LASTA);
            sb.push_back(e);
        end
    endtask

    // 200 ns low pulse; one cycle after detection the transfer must be running
    task automatic pulse_start(input bit new_xfer);
        @(negedge clk);
        if (new_xfer) prev_dv = -1;
        bus.i_Start = 1'b0;
        repeat (2) @(negedge clk);
        bus.i_Start = 1'b1;
        chk("fin_clear_on_start", 32'(bus.o_Fin), 32'd0);
        chk("busy_on_start", 32'(bus.o_Busy), 32'd1);
    endtask

    task automatic wait_fin(input int lim);
        int n = 0;
        while (bus.o_Fin !== 1'b1 && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("fin_reached", 32'(bus.o_Fin), 32'd1);
        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_frame_addr(input int a, input int lim);
        int n = 0;
        while (!(int'(bus.o_Addr) == a && bus.o_Tx_Active === 1'b1) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("reached_frame", 32'(n < lim), 32'd1);
    endtask

    initial begin
        #(100 * 20000);
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int f0;
    int r0;
    initial begin
        bus.i_Start = 1'b1;
        rst = 1'b1;
        repeat (500) @(negedge clk);
        chk("rst_serial", 32'(bus.o_Tx_Serial), 32'd1);
        chk("rst_addr", 32'(bus.o_Addr), 32'd0);
        chk("rst_fin", 32'(bus.o_Fin), 32'd0);
        chk("rst_busy", 32'(bus.o_Busy), 32'd0);
        chk("rst_dv", 32'(bus.o_Tx_DV), 32'd0);
        chk("rst_active", 32'(bus.o_Tx_Active), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle_serial", 32'(bus.o_Tx_Serial), 32'd1);
        chk("idle_busy", 32'(bus.o_Busy), 32'd0);

        // Constant 0x3B from every address
        mode = 1'b0; f0 = frames; r0 = fin_rises;
        push_const();
        pulse_start(1'b1);
        wait_fin(400);
        chk("frames_const", 32'(frames - f0), 32'd4);
        chk("fin_rises_const", 32'(fin_rises - r0), 32'd1);
        repeat (50) @(negedge clk);
        chk("fin_held", 32'(bus.o_Fin), 32'd1);
        chk("addr_held_last", 32'(bus.o_Addr), 32'(LASTA));
        chk("no_extra_frames", 32'(frames - f0), 32'd4);

        // data = addr ^ 0xA5, restarted from DONE
        mode = 1'b1; f0 = frames; r0 = fin_rises;
        push_tbl();
        pulse_start(1'b1);
        wait_fin(400);
        chk("frames_xor", 32'(frames - f0), 32'd4);
        chk("fin_rises_xor", 32'(fin_rises - r0), 32'd1);

        // Second start during the frame for byte 1 must be ignored
        f0 = frames; r0 = fin_rises;
        push_tbl();
        pulse_start(1'b1);
        wait_frame_addr(1, 200);
        pulse_start(1'b0);
        wait_fin(400);
        repeat (100) @(negedge clk);
        chk("frames_ignored_start", 32'(frames - f0), 32'd4);
        chk("fin_rises_ignored_start", 32'(fin_rises - r0), 32'd1);
        chk("sb_empty_ignored_start", 32'(sb.size()), 32'd0);

        // Reset during a data bit of frame 2 (byte 0xA7, bit 3 = 0)
        mon_en = 1'b0;
        pulse_start(1'b1);
        wait_frame_addr(2, 300);
        repeat (17) @(negedge clk);
        chk("line_before_reset", 32'(bus.o_Tx_Serial), 32'd0);
        #10 rst = 1'b1;
        #1;
        chk("async_rst_serial", 32'(bus.o_Tx_Serial), 32'd1);
        chk("async_rst_addr", 32'(bus.o_Addr), 32'd0);
        chk("async_rst_busy", 32'(bus.o_Busy), 32'd0);
        chk("async_rst_active", 32'(bus.o_Tx_Active), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        mon_en = 1'b1; f0 = frames; r0 = fin_rises;
        push_tbl();
        pulse_start(1'b1);
        wait_fin(400);
        chk("frames_after_reset", 32'(frames - f0), 32'd4);
        chk("fin_rises_after_reset", 32'(fin_rises - r0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
